// File: rtl/tqvp_sample_fifo.sv
// ============================================================================
//  Module   : tqvp_sample_fifo
//  Brief    : 8-bit sample FIFO between the SPI register bus and the FIR.
//             Optional macro TQVP_FIFO_STATS_EN adds a dropped-sample counter
//             readable at address 0x4.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tqvp_sample_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] address,
    input  logic [7:0] data_in,
    input  logic       data_write,
    output logic [7:0] data_out,
    output logic [7:0] smp_data,
    output logic       smp_valid,
    input  logic       smp_ready,
    output logic       fifo_full,
    output logic       fifo_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] C_DEPTH     = CNT_W'(DEPTH);
    localparam logic [3:0]       ADDR_DATA   = 4'h0;
    localparam logic [3:0]       ADDR_STATUS = 4'h1;
    localparam logic [3:0]       ADDR_COUNT  = 4'h2;
    localparam logic [3:0]       ADDR_CTRL   = 4'h3;
    localparam logic [3:0]       ADDR_STATS  = 4'h4;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [0:DEPTH-1];
    logic [PTR_W-1:0] wptr_q,   wptr_d;
    logic [PTR_W-1:0] rptr_q,   rptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             full_q,   full_d;
    logic             empty_q,  empty_d;
    logic             ovf_q,    ovf_d;
    logic             out_en_q, out_en_d;

    // ------------------------------------------------------------------
    // Bus decode and handshake
    // ------------------------------------------------------------------
    logic w_wr_data;
    logic w_wr_status;
    logic w_wr_ctrl;
    logic w_flush;
    logic w_ovf_clr;
    logic w_valid;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_wr_data   = data_write && (address == ADDR_DATA);
    assign w_wr_status = data_write && (address == ADDR_STATUS);
    assign w_wr_ctrl   = data_write && (address == ADDR_CTRL);
    assign w_flush     = w_wr_status && data_in[0];
    assign w_ovf_clr   = w_wr_status && data_in[7];

    // Outputs are forced to their cleared values while rst is held so the
    // consumer never sees a stale sample during reset.
    assign w_valid = out_en_q && !empty_q && !rst;
    assign w_pop   = w_valid && smp_ready;
    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign w_push  = w_wr_data && (!full_q || w_pop);
    assign w_drop  = w_wr_data && full_q && !w_pop;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        out_en_d = out_en_q;

        if (w_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (w_push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (w_pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // A new overflow beats a clear issued in the same cycle.
        if (w_drop) begin
            ovf_d = 1'b1;
        end else if (w_ovf_clr) begin
            ovf_d = 1'b0;
        end

        if (w_wr_ctrl) begin
            out_en_d = data_in[0];
        end

        full_d  = (count_d == C_DEPTH);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            out_en_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            out_en_q <= out_en_d;
        end
    end

    // Sample storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push && !w_flush) begin
            mem_q[wptr_q] <= data_in;
        end
    end

    // ------------------------------------------------------------------
    // Dropped-sample statistics
    // ------------------------------------------------------------------
    logic [7:0] w_stats_rd;

`ifdef TQVP_FIFO_STATS_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (w_ovf_clr) begin
            drop_cnt_d = 8'h00;
        end else if (w_drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'h01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 8'h00;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign w_stats_rd = rst ? 8'h00 : drop_cnt_q;
`else
    assign w_stats_rd = 8'h00;
`endif

    // ------------------------------------------------------------------
    // Read-back and consumer outputs
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] w_count_vis;
    logic             w_full_vis;
    logic             w_empty_vis;
    logic             w_ovf_vis;
    logic             w_out_en_vis;
    logic [7:0]       w_head;

    assign w_count_vis  = rst ? '0 : count_q;
    assign w_full_vis   = full_q & ~rst;
    assign w_empty_vis  = empty_q | rst;
    assign w_ovf_vis    = ovf_q & ~rst;
    assign w_out_en_vis = out_en_q & ~rst;
    assign w_head       = mem_q[rptr_q];

    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_DATA:   data_out = w_empty_vis ? 8'h00 : w_head;
            ADDR_STATUS: data_out = {w_ovf_vis, 5'b00000, w_full_vis, w_empty_vis};
            ADDR_COUNT:  data_out = {{(8-CNT_W){1'b0}}, w_count_vis};
            ADDR_CTRL:   data_out = {7'b0000000, w_out_en_vis};
            ADDR_STATS:  data_out = w_stats_rd;
            default:     data_out = 8'h00;
        endcase
    end

    assign smp_data   = w_head;
    assign smp_valid  = w_valid;
    assign fifo_full  = w_full_vis;
    assign fifo_empty = w_empty_vis;

endmodule

`default_nettype wire

// File: tb/tb_tqvp_sample_fifo.sv
// ============================================================================
//  Module   : tb_tqvp_sample_fifo
//  Brief    : Scoreboard bench for tqvp_sample_fifo (DEPTH = 8).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tqvp_sample_fifo;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] address;
    logic [7:0] data_in;
    logic       data_write;
    logic [7:0] data_out;
    logic [7:0] smp_data;
    logic       smp_valid;
    logic       smp_ready;
    logic       fifo_full;
    logic       fifo_empty;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic       m_ovf;
    logic [7:0] m_drops;

    tqvp_sample_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .data_in    (data_in),
        .data_write (data_write),
        .data_out   (data_out),
        .smp_data   (smp_data),
        .smp_valid  (smp_valid),
        .smp_ready  (smp_ready),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Single-cycle bus write; entered and left at posedge + 1.
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(posedge clk);
        #1;
        data_write = 1'b0;
    endtask

    // Register read sampled mid-cycle; returns at posedge + 1.
    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        address = a;
        #1;
        d = data_out;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_status();
        return {m_ovf, 5'b00000, (exp_q.size() == DEPTH), (exp_q.size() == 0)};
    endfunction

    function automatic logic [7:0] exp_stats();
`ifdef TQVP_FIFO_STATS_EN
        return m_drops;
`else
        return 8'h00;
`endif
    endfunction

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1; address = 4'h0; data_in = 8'h00; data_write = 1'b0; smp_ready = 1'b0;
        exp_q.delete(); m_ovf = 1'b0; m_drops = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (smp_valid !== 1'b0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got valid=%b empty=%b full=%b, expected 0 1 0", smp_valid, fifo_empty, fifo_full);
        end
        rd(4'h1, v);
        n_checks++;
        if (v !== 8'h01) begin n_fail++; $display("FAIL reset_status: got %h, expected 01", v); end
        rst = 1'b0;
        rd(4'h2, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL reset_count: got %h, expected 00", v); end
        rd(4'h3, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl: got %h, expected 00", v); end
    endtask

    task automatic test_basic();
        logic [7:0] v;
        wr(4'h3, 8'hFF);
        rd(4'h3, v);
        n_checks++;
        if (v !== 8'h01) begin n_fail++; $display("FAIL ctrl_readback: got %h, expected 01", v); end
        // First push into an empty FIFO must not be visible combinationally.
        address = 4'h0; data_in = 8'h11; data_write = 1'b1;
        @(negedge clk);
        n_checks++;
        if (smp_valid !== 1'b0) begin n_fail++; $display("FAIL no_bypass: got valid=%b, expected 0", smp_valid); end
        @(posedge clk);
        #1;
        data_write = 1'b0;
        exp_q.push_back(8'h11);
        @(negedge clk);
        n_checks++;
        if (smp_valid !== 1'b1) begin n_fail++; $display("FAIL push_latency: got valid=%b, expected 1", smp_valid); end
        @(posedge clk);
        #1;
        wr(4'h0, 8'h22);
        exp_q.push_back(8'h22);
        wr(4'h7, 8'h5A);
        rd(4'h7, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL unmapped_read: got %h, expected 00", v); end
        rd(4'h2, v);
        n_checks++;
        if (v !== 8'(exp_q.size())) begin n_fail++; $display("FAIL basic_count: got %h, expected %h", v, 8'(exp_q.size())); end
        rd(4'h0, v);
        n_checks++;
        if (v !== exp_q[0] || smp_data !== exp_q[0] || smp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_head: got data=%h smp=%h valid=%b, expected %h %h 1", v, smp_data, smp_valid, exp_q[0], exp_q[0]);
        end
    endtask

    task automatic test_drain_consecutive();
        smp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (smp_valid !== 1'b1 || smp_data !== exp_q[0]) begin
                n_fail++;
                $display("FAIL consec_pop%0d: got valid=%b data=%h, expected 1 %h", i, smp_valid, smp_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        smp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (fifo_empty !== 1'b1 || smp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drained: got empty=%b valid=%b, expected 1 0", fifo_empty, smp_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        for (int i = 0; i < 9; i++) begin
            wr(4'h0, 8'hA0 + 8'(i));
            if (exp_q.size() < DEPTH) exp_q.push_back(8'hA0 + 8'(i));
            else begin m_ovf = 1'b1; m_drops++; end
        end
        rd(4'h2, v);
        n_checks++;
        if (v !== 8'(DEPTH)) begin n_fail++; $display("FAIL ovf_count: got %h, expected %h", v, 8'(DEPTH)); end
        rd(4'h1, v);
        n_checks++;
        if (v !== exp_status() || fifo_full !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_status: got %h full=%b, expected %h 1", v, fifo_full, exp_status());
        end
        rd(4'h4, v);
        n_checks++;
        if (v !== exp_stats()) begin n_fail++; $display("FAIL ovf_stats: got %h, expected %h", v, exp_stats()); end
        wr(4'h1, 8'h80);
        m_ovf = 1'b0; m_drops = 8'h00;
        rd(4'h1, v);
        n_checks++;
        if (v !== exp_status()) begin n_fail++; $display("FAIL ovf_clear: got %h, expected %h", v, exp_status()); end
        rd(4'h4, v);
        n_checks++;
        if (v !== exp_stats()) begin n_fail++; $display("FAIL stats_clear: got %h, expected %h", v, exp_stats()); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] v;
        logic [7:0] last;
        address = 4'h0; data_in = 8'h55; data_write = 1'b1; smp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (smp_valid !== 1'b1 || smp_data !== exp_q[0]) begin
            n_fail++;
            $display("FAIL full_pp_pop: got valid=%b data=%h, expected 1 %h", smp_valid, smp_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        exp_q.push_back(8'h55);
        @(posedge clk);
        #1;
        data_write = 1'b0; smp_ready = 1'b0;
        rd(4'h2, v);
        n_checks++;
        if (v !== 8'(DEPTH)) begin n_fail++; $display("FAIL full_pp_count: got %h, expected %h", v, 8'(DEPTH)); end
        rd(4'h1, v);
        n_checks++;
        if (v !== exp_status()) begin n_fail++; $display("FAIL full_pp_status: got %h, expected %h", v, exp_status()); end
        last = 8'h00;
        smp_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            n_checks++;
            if (smp_valid !== 1'b1 || smp_data !== exp_q[0]) begin
                n_fail++;
                $display("FAIL full_pp_drain%0d: got valid=%b data=%h, expected 1 %h", i, smp_valid, smp_data, exp_q[0]);
            end
            last = smp_data;
            void'(exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        smp_ready = 1'b0;
        n_checks++;
        if (last !== 8'h55 || fifo_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pp_last: got last=%h empty=%b, expected 55 1", last, fifo_empty);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] v;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 5; k++) begin
                wr(4'h0, 8'((b * 16) + k + 1));
                exp_q.push_back(8'((b * 16) + k + 1));
            end
            smp_ready = 1'b1;
            for (int p = 0; p < 4; p++) begin
                @(negedge clk);
                n_checks++;
                if (smp_valid !== 1'b1 || smp_data !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL wrap_b%0d_p%0d: got valid=%b data=%h, expected 1 %h", b, p, smp_valid, smp_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            @(posedge clk);
            #1;
            smp_ready = 1'b0;
        end
        rd(4'h2, v);
        n_checks++;
        if (v !== 8'(exp_q.size())) begin n_fail++; $display("FAIL wrap_count: got %h, expected %h", v, 8'(exp_q.size())); end
        smp_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            n_checks++;
            if (smp_valid !== 1'b1 || smp_data !== exp_q[0]) begin
                n_fail++;
                $display("FAIL wrap_drain%0d: got valid=%b data=%h, expected 1 %h", i, smp_valid, smp_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        smp_ready = 1'b0;
        rd(4'h1, v);
        n_checks++;
        if (v !== exp_status()) begin n_fail++; $display("FAIL wrap_status: got %h, expected %h", v, exp_status()); end
    endtask

    task automatic test_flush_and_reset();
        logic [7:0] v;
        for (int i = 0; i < 3; i++) begin
            wr(4'h0, 8'hC0 + 8'(i));
            exp_q.push_back(8'hC0 + 8'(i));
        end
        address = 4'h1; data_in = 8'h81; data_write = 1'b1; smp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (smp_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pop_setup: got valid=%b, expected 1", smp_valid); end
        @(posedge clk);
        #1;
        data_write = 1'b0;
        exp_q.delete(); m_ovf = 1'b0;
        @(negedge clk);
        n_checks++;
        if (smp_valid !== 1'b0 || fifo_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_valid: got valid=%b empty=%b, expected 0 1", smp_valid, fifo_empty);
        end
        @(posedge clk);
        #1;
        smp_ready = 1'b0;
        rd(4'h2, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL flush_count: got %h, expected 00", v); end
        rd(4'h1, v);
        n_checks++;
        if (v !== exp_status()) begin n_fail++; $display("FAIL flush_status: got %h, expected %h", v, exp_status()); end

        wr(4'h0, 8'hD1);
        wr(4'h0, 8'hD2);
        rst = 1'b1; address = 4'h0; data_in = 8'h77; data_write = 1'b1; smp_ready = 1'b1;
        @(posedge clk);
        #1;
        data_write = 1'b0; smp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (smp_valid !== 1'b0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_flags: got valid=%b empty=%b full=%b, expected 0 1 0", smp_valid, fifo_empty, fifo_full);
        end
        rd(4'h2, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL midrst_count: got %h, expected 00", v); end
        rst = 1'b0;
        rd(4'h3, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL midrst_ctrl: got %h, expected 00", v); end
        wr(4'h0, 8'h99);
        rd(4'h2, v);
        n_checks++;
        if (v !== 8'h01 || smp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL postrst_push: got count=%h valid=%b, expected 01 0", v, smp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drain_consecutive();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_flush_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tqvp_sample_fifo.md
TQVP_SAMPLE_FIFO -- requirements
Module: tqvp_sample_fifo

Purpose: sample buffer between the SPI register bus and the FIR peripheral. Bus writes push 8-bit samples; the FIR pops them over a valid/ready handshake.

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in samples; legal values are powers of two from 2 to 16.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 address  input  4  register address from the SPI register bus.
REQ-005 data_in  input  8  write data from the bus.
REQ-006 data_write  input  1  one-cycle write strobe, qualifying address/data_in.
REQ-007 data_out  output  8  read data for the current address; combinational from address and state.
REQ-008 smp_data  output  8  FIFO head sample.
REQ-009 smp_valid  output  1  head sample available to the consumer.
REQ-010 smp_ready  input  1  consumer accepts the head sample.
REQ-011 fifo_full  output  1  occupancy equals DEPTH.
REQ-012 fifo_empty  output  1  occupancy equals 0.

Function
REQ-013 Register map: 0x0 DATA; 0x1 STATUS; 0x2 COUNT; 0x3 CTRL; all other addresses SHALL read 0x00 and ignore writes.
REQ-014 DATA write: pushes data_in if not full. DATA read returns the head sample, or 0x00 when empty; a read SHALL NOT pop.
REQ-015 STATUS read: {overflow, 5'b0, full, empty}.
REQ-016 STATUS write: bit7=1 clears the overflow flag; bit0=1 flushes the FIFO (occupancy 0, pointers 0).
REQ-017 COUNT read: zero-extended occupancy, range 0..DEPTH.
REQ-018 CTRL bit0 = out_en, read/write; bits 7:1 SHALL read 0.
REQ-019 smp_valid = out_en AND NOT empty; smp_data = storage at the read pointer.
REQ-020 A pop SHALL occur exactly in cycles where smp_valid AND smp_ready are both high.
REQ-021 Push-to-valid latency: a sample pushed into an empty FIFO SHALL assert smp_valid in the next cycle; there is no combinational bypass.
REQ-022 Write to DATA when full with no pop in the same cycle: data is dropped, overflow set (sticky), occupancy unchanged.
REQ-023 Write to DATA when full with a pop in the same cycle: push accepted, occupancy stays DEPTH, overflow not set.
REQ-024 Simultaneous push and pop when not full: occupancy unchanged, both pointers advance.
REQ-025 Pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by occupancy, not by pointer equality.
REQ-026 Flush in the same cycle as a pop: flush wins; a pop handshake in that cycle SHALL NOT advance state beyond the flush.
REQ-027 Overflow-clear and a new overflow in the same cycle: overflow ends set.
REQ-028 fifo_full and fifo_empty SHALL be registered-state derived, glitch-free, and valid in the same cycle as COUNT.

Reset
REQ-029 rst high at a clock edge SHALL set occupancy 0, both pointers 0, overflow 0, out_en 0.
REQ-030 While rst is high or after reset: smp_valid=0, fifo_empty=1, fifo_full=0, data_out per map with cleared state.
REQ-031 Storage contents need not be reset.
REQ-032 Reset asserted mid-operation SHALL discard all buffered samples; any push or pop in that cycle SHALL be ignored.

Configuration
REQ-033 Macro TQVP_FIFO_STATS_EN.
- Defined: address 0x4 SHALL read an 8-bit saturating count of dropped samples (saturates at 0xFF). It is cleared by reset and by an overflow-clear write.
- Undefined: address 0x4 SHALL read 0x00, and no counter logic SHALL be present.

Verification
REQ-034 Reset, set out_en, write DATA 0x11, 0x22 with smp_ready=0 -> COUNT=2, smp_valid=1, smp_data=0x11.
REQ-035 Hold smp_ready=1 with the FIFO holding 0x11, 0x22 -> pops 0x11 then 0x22 on consecutive cycles; then fifo_empty=1, smp_valid=0.
REQ-036 DEPTH=8: write 9 samples with smp_ready=0 -> COUNT=8, STATUS=0x82, 9th sample absent on drain. STATS_EN defined: reg 0x4 reads 0x01.
REQ-037 FIFO full with smp_ready=1, write 0x55 in the same cycle -> COUNT stays 8, overflow=0, 0x55 emerges last.
REQ-038 Load 20 samples in batches with interleaved pops -> pointer wrap correct, output order preserved.
REQ-039 Fill to 3, then STATUS write 0x81 concurrent with a pop -> COUNT=0, overflow=0, smp_valid=0 next cycle; assert rst mid-stream -> all outputs at reset values.
